// File: rtl/input_frame_buffer.sv
// Ping-pong input frame buffer: fills one bank of FRAME_LEN samples while the other is read out.
// Optional frame counter output enabled by defining IBUF_FRAME_CNT_EN.

module ifb_bank #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = 3
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  // Sample storage is deliberately not reset; the full flags gate all reads.
  logic [DATA_W-1:0] mem_q [FRAME_LEN];

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

module input_frame_buffer #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              buf_en,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              wr_flush,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last,
  output logic              frame_avail,
  input  logic              ovf_clr,
  output logic              overflow
`ifdef IBUF_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_last_q, dout_last_d;
  logic              overflow_q, overflow_d;

  logic              accept, do_write, do_drop, wr_done, do_read, rd_done;
  logic [1:0]        bank_we;
  logic [DATA_W-1:0] bank_rdata [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ifb_bank #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) u_bank (
      .CLK   (CLK),
      .we    (bank_we[b]),
      .waddr (wr_idx_q),
      .wdata (din),
      .raddr (rd_idx_q),
      .rdata (bank_rdata[b])
    );
  end

  always_comb begin
    // Flush wins over a same-cycle sample; that sample is neither stored nor counted as overflow.
    accept   = buf_en & din_valid & ~wr_flush;
    do_write = accept & ~full_q[wr_bank_q];
    do_drop  = accept & full_q[wr_bank_q];
    wr_done  = do_write & (wr_idx_q == LAST_IDX);
    do_read  = rd_en & full_q[rd_bank_q];
    rd_done  = do_read & (rd_idx_q == LAST_IDX);

    bank_we            = '0;
    bank_we[wr_bank_q] = do_write;

    // wr_done needs an empty bank and rd_done a full one, so they never target the same bank.
    full_d = full_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (wr_done) full_d[wr_bank_q] = 1'b1;

    wr_bank_d = wr_bank_q ^ wr_done;
    wr_idx_d  = wr_idx_q;
    if (wr_flush)      wr_idx_d = '0;
    else if (do_write) wr_idx_d = wr_done ? '0 : wr_idx_q + 1'b1;

    rd_bank_d = rd_bank_q ^ rd_done;
    rd_idx_d  = rd_idx_q;
    if (do_read) rd_idx_d = rd_done ? '0 : rd_idx_q + 1'b1;

    dout_d       = do_read ? bank_rdata[rd_bank_q] : dout_q;
    dout_valid_d = do_read;
    dout_last_d  = rd_done;

    overflow_d = overflow_q;
    if (do_drop)      overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      overflow_q   <= overflow_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign dout_last   = dout_last_q;
  assign overflow    = overflow_q;
  assign frame_avail = full_q[rd_bank_q];

`ifdef IBUF_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + 16'(wr_done);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  // No frame counter in this build.
`endif
endmodule

// File: tb/tb_input_frame_buffer.sv
// Scoreboard bench for input_frame_buffer: reads push expected samples, a negedge monitor checks dout.

module tb_input_frame_buffer;
  logic        CLK, RESET;
  logic        buf_en, din_valid, wr_flush, rd_en, ovf_clr;
  logic [15:0] din, dout;
  logic        dout_valid, dout_last, frame_avail, overflow;
`ifdef IBUF_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;
  exp_t exp_q[$];

  input_frame_buffer #(.DATA_W(16), .FRAME_LEN(8), .IDX_W(3)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .buf_en      (buf_en),
    .din         (din),
    .din_valid   (din_valid),
    .wr_flush    (wr_flush),
    .rd_en       (rd_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_last   (dout_last),
    .frame_avail (frame_avail),
    .ovf_clr     (ovf_clr),
    .overflow    (overflow)
`ifdef IBUF_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; p pushes the expected read response.
  task automatic step(input logic w, input logic [15:0] d, input logic r,
                      input logic p, input logic [15:0] e, input logic l);
    buf_en = w; din_valid = w; din = d; rd_en = r;
    if (p) exp_q.push_back('{d: e, l: l});
    @(posedge CLK); #1;
    buf_en = 1'b0; din_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [15:0] d);
    step(1'b1, d, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] e, input logic l);
    step(1'b0, 16'h0, 1'b1, 1'b1, e, l);
  endtask

  task automatic wr_frame(input logic [15:0] base);
    for (int i = 0; i < 8; i++) wr(base + 16'(i));
  endtask

  task automatic rd_frame(input logic [15:0] base);
    for (int i = 0; i < 8; i++) rd(base + 16'(i), i == 7);
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!RESET && dout_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got dout %0h last %0b, expected no dout_valid", dout, dout_last);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e.d || dout_last !== e.l) begin
          errors++;
          $display("FAIL read_data: got dout %0h last %0b expected %0h last %0b", dout, dout_last, e.d, e.l);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1; buf_en = 0; din_valid = 0; din = 0; wr_flush = 0; rd_en = 0; ovf_clr = 0;
    #2;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_frame_avail", frame_avail, 0);
    chk("rst_overflow", overflow, 0);
`ifdef IBUF_FRAME_CNT_EN
    chk("rst_frame_cnt", frame_cnt, 0);
`endif
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // Basic frame: 1..8 then read back
    for (int i = 1; i <= 7; i++) wr(16'(i));
    chk("t1_avail_before_8th", frame_avail, 0);
    wr(16'h0008);
    chk("t1_avail_after_8th", frame_avail, 1);
    rd_frame(16'h0001);
    chk("t1_avail_after_read", frame_avail, 0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);   // read with nothing available
    chk("t1_ignored_dout_valid", dout_valid, 0);
    chk("t1_ignored_dout_hold", dout, 16'h0008);

    // Both banks full, overflow, set beats clear
    wr_frame(16'h0010);
    wr_frame(16'h0018);
    chk("t2_avail", frame_avail, 1);
    chk("t2_no_ovf_yet", overflow, 0);
    wr(16'hDEAD);
    chk("t2_ovf_set", overflow, 1);
    ovf_clr = 1'b1; wr(16'hBEEF); ovf_clr = 1'b0;
    chk("t2_ovf_set_beats_clr", overflow, 1);
    ovf_clr = 1'b1; @(posedge CLK); #1 ovf_clr = 1'b0;
    chk("t2_ovf_cleared", overflow, 0);
    rd_frame(16'h0010);
    chk("t2_second_avail", frame_avail, 1);
    rd_frame(16'h0018);
    chk("t2_avail_after", frame_avail, 0);

    // buf_en gap mid-frame; din_valid alone must not write
    for (int i = 0; i < 3; i++) wr(16'h0020 + 16'(i));
    din_valid = 1'b1; din = 16'hBAD0;
    repeat (10) @(posedge CLK);
    #1 din_valid = 1'b0;
    chk("t3_avail_gap", frame_avail, 0);
    for (int i = 3; i < 7; i++) wr(16'h0020 + 16'(i));
    chk("t3_avail_before_8th", frame_avail, 0);
    wr(16'h0027);
    chk("t3_avail_after_8th", frame_avail, 1);
    rd_frame(16'h0020);

    // Flush discards a partial frame; flush with a write drops it without overflow
    for (int i = 0; i < 5; i++) wr(16'h00A0 + 16'(i));
    wr_flush = 1'b1; wr(16'hBEEF); wr_flush = 1'b0;
    chk("t4_flush_no_ovf", overflow, 0);
    chk("t4_avail_after_flush", frame_avail, 0);
    wr_frame(16'h0100);
    chk("t4_avail", frame_avail, 1);
    rd_frame(16'h0100);
    chk("t4_avail_after", frame_avail, 0);

    // Continuous streaming over 4 frames
    wr_frame(16'h0200);
    for (int i = 0; i < 24; i++)
      step(1'b1, 16'h0208 + 16'(i), 1'b1, 1'b1, 16'h0200 + 16'(i), (i % 8) == 7);
    chk("t5_stream_no_ovf", overflow, 0);
    chk("t5_last_frame_avail", frame_avail, 1);
    rd_frame(16'h0218);
    chk("t5_avail_after", frame_avail, 0);

    // Write into the bank whose last sample is read in the same cycle
    wr_frame(16'h0300);
    wr_frame(16'h0308);
    for (int i = 0; i < 7; i++) rd(16'h0300 + 16'(i), 1'b0);
    step(1'b1, 16'hC0DE, 1'b1, 1'b1, 16'h0307, 1'b1);
    chk("t5_collision_ovf", overflow, 1);
    ovf_clr = 1'b1; @(posedge CLK); #1 ovf_clr = 1'b0;
    chk("t5_collision_ovf_clr", overflow, 0);
    rd_frame(16'h0308);
    chk("t5_collision_dropped", frame_avail, 0);

    // Async reset in the middle of reading frame 2
    wr_frame(16'h0400);
    wr_frame(16'h0408);
    wr(16'h04FF);
    chk("t6_ovf_before_rst", overflow, 1);
    rd_frame(16'h0400);
    for (int i = 0; i < 3; i++) rd(16'h0408 + 16'(i), 1'b0);
    rd_en = 1'b1;
    @(negedge CLK); #1;
    RESET = 1'b1;
    #1;
    chk("t6_rst_dout_valid", dout_valid, 0);
    chk("t6_rst_frame_avail", frame_avail, 0);
    chk("t6_rst_overflow", overflow, 0);
`ifdef IBUF_FRAME_CNT_EN
    chk("t6_rst_frame_cnt", frame_cnt, 0);
`endif
    @(posedge CLK); #1;
    rd_en = 1'b0; RESET = 1'b0;
    chk("t6_after_rst_avail", frame_avail, 0);
`ifdef IBUF_FRAME_CNT_EN
    wr_frame(16'h0500);
    wr_frame(16'h0508);
    rd_frame(16'h0500);
    wr_frame(16'h0510);
    chk("t6_frame_cnt_3", frame_cnt, 3);
    rd_frame(16'h0508);
    rd_frame(16'h0510);
`endif

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
